// File: rtl/adc_acq_wingen_multi_if.sv
// Bus bundle for the multi-echo ADC acquisition window generator.
// The master drives the count inputs and ACQ_WND; the slave (the generator) drives the status outputs.
interface adc_acq_wingen_multi_if #(
    parameter int DATABUS_WIDTH = 32
);
    logic [DATABUS_WIDTH-1:0] ADC_INIT_DELAY;
    logic [DATABUS_WIDTH-1:0] SAMPLES_PER_ECHO;
    logic [DATABUS_WIDTH-1:0] NUM_ECHOES;
    logic [DATABUS_WIDTH-1:0] ECHO_GAP;
    logic                     ACQ_WND;
    logic                     ACQ_EN;
    logic                     ACQ_START;
    logic                     ACQ_DONE;
    logic                     ACQ_ABORT;
    logic                     BUSY;
    logic [DATABUS_WIDTH-1:0] ECHO_IDX;
    logic [7:0]               RETRIG_CNT;

    modport master (
        output ADC_INIT_DELAY, SAMPLES_PER_ECHO, NUM_ECHOES, ECHO_GAP, ACQ_WND,
        input  ACQ_EN, ACQ_START, ACQ_DONE, ACQ_ABORT, BUSY, ECHO_IDX, RETRIG_CNT
    );

    modport slave (
        input  ADC_INIT_DELAY, SAMPLES_PER_ECHO, NUM_ECHOES, ECHO_GAP, ACQ_WND,
        output ACQ_EN, ACQ_START, ACQ_DONE, ACQ_ABORT, BUSY, ECHO_IDX, RETRIG_CNT
    );
endinterface

// File: rtl/adc_acq_wingen_multi.sv
// Multi-echo ADC acquisition window generator: delay, then NUM_ECHOES windows separated by gaps.
// Optional feature macro: ACQ_WINGEN_ABORT_EN (ACQ_WND falling mid-train aborts the train).
module adc_acq_wingen_multi #(
    parameter int DATABUS_WIDTH = 32,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                  CLK,
    input  logic                  RESET,
    adc_acq_wingen_multi_if.slave bus
);

    localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam logic [DATABUS_WIDTH-1:0] ONE = DATABUS_WIDTH'(1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DELAY = 2'd1;
    localparam logic [1:0] ST_ACQ   = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

    logic [SYNC_N-1:0]        r_sync;
    logic                     r_sync_prev;
    logic                     r_trig;
    logic [1:0]               r_state;
    logic [DATABUS_WIDTH-1:0] r_cnt;
    logic [DATABUS_WIDTH-1:0] r_samples;
    logic [DATABUS_WIDTH-1:0] r_num;
    logic [DATABUS_WIDTH-1:0] r_gap;
    logic [DATABUS_WIDTH-1:0] r_echo_idx;
    logic [7:0]               r_retrig;
    logic                     r_acq_en;
    logic                     r_acq_start;
    logic                     r_acq_done;
    logic                     r_acq_abort;
    logic                     r_busy;

    logic                     w_sync;
    logic                     w_abort;
    logic                     w_cnt_zero;
    logic                     w_last_echo;
    logic                     w_zero_cfg;
    logic [DATABUS_WIDTH-1:0] w_delay_m1;

    assign w_sync      = r_sync[SYNC_N-1];
    assign w_cnt_zero  = (r_cnt == '0);
    assign w_last_echo = (r_echo_idx == r_num - ONE);
    assign w_zero_cfg  = (bus.SAMPLES_PER_ECHO == '0) || (bus.NUM_ECHOES == '0);
    assign w_delay_m1  = (bus.ADC_INIT_DELAY == '0) ? '0 : bus.ADC_INIT_DELAY - ONE;

`ifdef ACQ_WINGEN_ABORT_EN
    assign w_abort = (r_state != ST_IDLE) && !w_sync;
`else
    assign w_abort = 1'b0;
`endif

    // Trigger is registered once more after the edge compare, so edges during a train are consumed.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_sync      <= '0;
            r_sync_prev <= 1'b0;
            r_trig      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let the chain shift one stage per clock regardless of statement order.
            r_sync      <= {r_sync[SYNC_N-2:0], bus.ACQ_WND};
            r_sync_prev <= w_sync;
            r_trig      <= w_sync & ~r_sync_prev;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_retrig <= '0;
        end else if (r_trig && (r_state != ST_IDLE) && (r_retrig != 8'hFF)) begin
            r_retrig <= r_retrig + 8'd1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_samples   <= '0;
            r_num       <= '0;
            r_gap       <= '0;
            r_echo_idx  <= '0;
            r_acq_en    <= 1'b0;
            r_acq_start <= 1'b0;
            r_acq_done  <= 1'b0;
            r_acq_abort <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_acq_start <= 1'b0;
            r_acq_done  <= 1'b0;
            r_acq_abort <= 1'b0;
            if (w_abort) begin
                r_state     <= ST_IDLE;
                r_acq_en    <= 1'b0;
                r_busy      <= 1'b0;
                r_echo_idx  <= '0;
                r_acq_abort <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (r_trig) begin
                            r_samples <= bus.SAMPLES_PER_ECHO;
                            r_num     <= bus.NUM_ECHOES;
                            r_gap     <= bus.ECHO_GAP;
                            if (w_zero_cfg) begin
                                r_acq_done <= 1'b1;
                            end else begin
                                r_state <= ST_DELAY;
                                r_cnt   <= w_delay_m1;
                                r_busy  <= 1'b1;
                            end
                        end
                    end
                    ST_DELAY: begin
                        if (w_cnt_zero) begin
                            r_state     <= ST_ACQ;
                            r_cnt       <= r_samples - ONE;
                            r_acq_en    <= 1'b1;
                            r_acq_start <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - ONE;
                        end
                    end
                    ST_ACQ: begin
                        if (!w_cnt_zero) begin
                            r_cnt <= r_cnt - ONE;
                        end else if (w_last_echo) begin
                            r_state    <= ST_IDLE;
                            r_acq_en   <= 1'b0;
                            r_busy     <= 1'b0;
                            r_acq_done <= 1'b1;
                            r_echo_idx <= '0;
                        end else begin
                            r_echo_idx <= r_echo_idx + ONE;
                            if (r_gap == '0) begin
                                // Zero gap: the next echo starts immediately with ACQ_EN held high.
                                r_cnt       <= r_samples - ONE;
                                r_acq_start <= 1'b1;
                            end else begin
                                r_state  <= ST_GAP;
                                r_cnt    <= r_gap - ONE;
                                r_acq_en <= 1'b0;
                            end
                        end
                    end
                    ST_GAP: begin
                        if (w_cnt_zero) begin
                            r_state     <= ST_ACQ;
                            r_cnt       <= r_samples - ONE;
                            r_acq_en    <= 1'b1;
                            r_acq_start <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - ONE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.ACQ_EN     = r_acq_en;
    assign bus.ACQ_START  = r_acq_start;
    assign bus.ACQ_DONE   = r_acq_done;
    assign bus.ACQ_ABORT  = r_acq_abort;
    assign bus.BUSY       = r_busy;
    assign bus.ECHO_IDX   = r_echo_idx;
    assign bus.RETRIG_CNT = r_retrig;

endmodule

// File: tb/tb_adc_acq_wingen_multi.sv
// Self-checking bench for adc_acq_wingen_multi: a timeline model built from trigger times,
// directed trains with literal expectations, random stimulus, retrigger saturation and reset.
module tb_adc_acq_wingen_multi;
    localparam int DW = 32;
    localparam int SS = 2;

    logic CLK = 1'b0;
    logic RESET;
    int   n_pass = 0;
    int   n_total = 0;

    adc_acq_wingen_multi_if #(.DATABUS_WIDTH(DW)) bus ();

    adc_acq_wingen_multi #(.DATABUS_WIDTH(DW), .SYNC_STAGES(SS)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Model: a train is fully described by its accept time t0 and latched counts; outputs are
    // derived from the offset r = now - t0 with plain arithmetic.
    logic [7:0] wh;
    longint     cyc, t0, m_len, md, ms, mn, mg;
    bit         has_train;
    int         m_retrig;
    logic       e_en, e_start, e_done, e_busy;
    longint     e_idx;

    initial forever begin
        @(posedge CLK or posedge RESET);
        if (RESET) begin
            wh = '0; cyc = 0; t0 = 0; m_len = 0; has_train = 0; m_retrig = 0;
            e_en = 0; e_start = 0; e_done = 0; e_busy = 0; e_idx = 0;
        end else begin
            longint r, q, k, m;
            cyc++;
            wh = {wh[6:0], bus.ACQ_WND};
            if (wh[SS+1] && !wh[SS+2]) begin
                if (!has_train || (cyc - t0) > m_len) begin
                    md = (bus.ADC_INIT_DELAY == 0) ? 1 : longint'(bus.ADC_INIT_DELAY);
                    ms = longint'(bus.SAMPLES_PER_ECHO);
                    mn = longint'(bus.NUM_ECHOES);
                    mg = longint'(bus.ECHO_GAP);
                    m_len = (ms == 0 || mn == 0) ? 0 : md + mn * ms + (mn - 1) * mg;
                    t0 = cyc;
                    has_train = 1;
                end else if (m_retrig < 255) begin
                    m_retrig++;
                end
            end
            r = cyc - t0;
            e_busy = has_train && r < m_len;
            e_done = has_train && r == m_len;
            e_en = 0; e_start = 0; e_idx = 0;
            if (has_train && r >= md && r < m_len) begin
                q = r - md;
                k = q / (ms + mg);
                m = q % (ms + mg);
                e_en    = (m < ms);
                e_start = (m == 0);
                e_idx   = (m < ms) ? k : k + 1;
            end
        end
    end

    initial forever begin
        @(negedge CLK);
        if (!RESET) begin
            check("acq_en",     bus.ACQ_EN,     e_en);
            check("acq_start",  bus.ACQ_START,  e_start);
            check("acq_done",   bus.ACQ_DONE,   e_done);
            check("busy",       bus.BUSY,       e_busy);
            check("echo_idx",   bus.ECHO_IDX,   e_idx);
            check("retrig_cnt", bus.RETRIG_CNT, m_retrig);
            check("acq_abort",  bus.ACQ_ABORT,  0);
        end
    end

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    // One ACQ_WND pulse, then literal per-offset patterns from T0 (bit r = value after edge T0+r).
    task automatic run_train(input string tag, input int d, input int s, input int n, input int g,
                             input int len, input logic [63:0] en_p, input logic [63:0] st_p,
                             input logic [63:0] dn_p, input logic [63:0] bz_p, input bit extra);
        int nst;
        @(negedge CLK);
        bus.ADC_INIT_DELAY = d; bus.SAMPLES_PER_ECHO = s; bus.NUM_ECHOES = n; bus.ECHO_GAP = g;
        bus.ACQ_WND = 1'b1;
        @(negedge CLK);
        bus.ACQ_WND = 1'b0;
        repeat (2) @(negedge CLK);
        nst = 0;
        for (int r = 0; r < len; r++) begin
            @(negedge CLK);
            check($sformatf("%s_en_r%0d", tag, r),   bus.ACQ_EN,    en_p[r]);
            check($sformatf("%s_st_r%0d", tag, r),   bus.ACQ_START, st_p[r]);
            check($sformatf("%s_done_r%0d", tag, r), bus.ACQ_DONE,  dn_p[r]);
            check($sformatf("%s_busy_r%0d", tag, r), bus.BUSY,      bz_p[r]);
            if (st_p[r]) begin
                check($sformatf("%s_idx_r%0d", tag, r), bus.ECHO_IDX, nst);
                nst++;
            end
            if (r == 0) begin
                bus.ADC_INIT_DELAY   = $urandom_range(7);
                bus.SAMPLES_PER_ECHO = $urandom_range(7);
                bus.NUM_ECHOES       = $urandom_range(7);
                bus.ECHO_GAP         = $urandom_range(7);
            end
            bus.ACQ_WND = extra && (r == 1 || r == 3 || r == 5);
        end
    endtask

    initial begin
        RESET = 1'b1;
        bus.ACQ_WND = 1'b0;
        bus.ADC_INIT_DELAY = '0; bus.SAMPLES_PER_ECHO = '0; bus.NUM_ECHOES = '0; bus.ECHO_GAP = '0;
        repeat (3) @(negedge CLK);
        check("rst_acq_en", bus.ACQ_EN, 0);
        check("rst_busy",   bus.BUSY, 0);
        check("rst_done",   bus.ACQ_DONE, 0);
        check("rst_idx",    bus.ECHO_IDX, 0);
        check("rst_retrig", bus.RETRIG_CNT, 0);
        RESET = 1'b0;
        repeat (4) @(negedge CLK);

        run_train("basic", 5, 4, 3, 2, 23, 64'h1E79E0, 64'h20820, 64'h200000, 64'h1FFFFF, 1'b0);
        repeat (3) @(negedge CLK);
        run_train("b2b", 0, 3, 2, 0, 9, 64'h7E, 64'h12, 64'h80, 64'h7F, 1'b0);
        repeat (3) @(negedge CLK);
        run_train("zero_s", 4, 0, 3, 1, 4, 64'h0, 64'h0, 64'h1, 64'h0, 1'b0);
        repeat (3) @(negedge CLK);
        run_train("zero_n", 4, 4, 0, 1, 4, 64'h0, 64'h0, 64'h1, 64'h0, 1'b0);
        repeat (3) @(negedge CLK);

        do_reset();
        run_train("retrig", 5, 4, 3, 2, 23, 64'h1E79E0, 64'h20820, 64'h200000, 64'h1FFFFF, 1'b1);
        check("retrig_cnt_3", bus.RETRIG_CNT, 3);
        repeat (3) @(negedge CLK);

        // Reset landing mid-echo: outputs clear at once, then a fresh train starts from echo 0.
        run_train("pre_rst", 5, 4, 3, 2, 8, 64'hE0, 64'h20, 64'h0, 64'hFF, 1'b0);
        #2 RESET = 1'b1;
        #1;
        check("midrst_acq_en", bus.ACQ_EN, 0);
        check("midrst_busy",   bus.BUSY, 0);
        check("midrst_idx",    bus.ECHO_IDX, 0);
        check("midrst_retrig", bus.RETRIG_CNT, 0);
        @(negedge CLK);
        RESET = 1'b0;
        repeat (3) @(negedge CLK);
        run_train("post_rst", 5, 4, 3, 2, 23, 64'h1E79E0, 64'h20820, 64'h200000, 64'h1FFFFF, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            if ($urandom_range(15) == 0) begin
                bus.ADC_INIT_DELAY   = $urandom_range(6);
                bus.SAMPLES_PER_ECHO = $urandom_range(5);
                bus.NUM_ECHOES       = $urandom_range(4);
                bus.ECHO_GAP         = $urandom_range(3);
            end
            bus.ACQ_WND = ($urandom_range(5) == 0);
        end
        bus.ACQ_WND = 1'b0;
        repeat (60) @(negedge CLK);

        // Saturation: 300 retriggers during one long train.
        do_reset();
        bus.ADC_INIT_DELAY = 2; bus.SAMPLES_PER_ECHO = 200; bus.NUM_ECHOES = 4; bus.ECHO_GAP = 5;
        bus.ACQ_WND = 1'b1;
        @(negedge CLK);
        bus.ACQ_WND = 1'b0;
        repeat (6) @(negedge CLK);
        for (int i = 0; i < 300; i++) begin
            bus.ACQ_WND = 1'b1;
            @(negedge CLK);
            bus.ACQ_WND = 1'b0;
            @(negedge CLK);
        end
        repeat (6) @(negedge CLK);
        check("retrig_sat", bus.RETRIG_CNT, 255);
        check("sat_busy_mid", bus.BUSY, 1);
        repeat (260) @(negedge CLK);
        check("sat_busy_end", bus.BUSY, 0);
        check("sat_retrig_end", bus.RETRIG_CNT, 255);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/adc_acq_wingen_multi.md
# adc_acq_wingen_multi

Multi-echo ADC acquisition window generator for the CPMG receive path. On each rising edge of the acquisition window from the pulse sequencer, it waits a programmable initial delay. It then emits a train of NUM_ECHOES ACQ_EN windows of SAMPLES_PER_ECHO cycles each, separated by ECHO_GAP idle cycles. It sits between the sequencer's ACQ_WND and the ADC FIFO write-enable, and replaces the single-window generator for echo-train acquisition.

## Interface
- DATABUS_WIDTH, 32, width of all count inputs and internal counters
- SYNC_STAGES, 2, flip-flop stages on ACQ_WND for clock domain crossing (minimum 2)
- CLK  in  1  system clock
- RESET  in  1  asynchronous, active-high reset
- ADC_INIT_DELAY  in  DATABUS_WIDTH  cycles from trigger to first ACQ_EN; 0 is treated as 1
- SAMPLES_PER_ECHO  in  DATABUS_WIDTH  ACQ_EN high cycles per echo
- NUM_ECHOES  in  DATABUS_WIDTH  windows per trigger
- ECHO_GAP  in  DATABUS_WIDTH  ACQ_EN low cycles between echoes
- ACQ_WND  in  1  acquisition window; asynchronous to CLK
- ACQ_EN  out  1  ADC capture enable
- ACQ_START  out  1  one-cycle pulse on the first ACQ_EN cycle of each echo
- ACQ_DONE  out  1  one-cycle pulse at normal end of train
- ACQ_ABORT  out  1  one-cycle pulse on abort (see Configuration)
- BUSY  out  1  high while a train is in progress
- ECHO_IDX  out  DATABUS_WIDTH  current echo index, 0-based
- RETRIG_CNT  out  8  count of ignored triggers, saturating at 255

## Operation
- ACQ_WND passes through SYNC_STAGES flops, then one edge-detect register. A trigger is sync high while the previous sync sample is low.
- The edge-detect register updates every cycle, so edges seen while BUSY are consumed and never queued.
- States: IDLE, DELAY, ACQ, GAP.
- IDLE + trigger:
  - latch all four count inputs;
  - if SAMPLES_PER_ECHO==0 or NUM_ECHOES==0: pulse ACQ_DONE next cycle, stay IDLE, never assert ACQ_EN;
  - else go to DELAY with counter = max(ADC_INIT_DELAY,1)-1.
- DELAY: decrement; at 0 go to ACQ with counter = SAMPLES_PER_ECHO-1.
- ACQ:
  - ACQ_EN=1; decrement;
  - at 0 with echoes remaining: ECHO_IDX increments; go to GAP with counter = ECHO_GAP-1, or straight back to ACQ if ECHO_GAP==0;
  - at 0 on the last echo: go to IDLE.
- GAP: ACQ_EN=0; at counter 0 go to ACQ.
- Trigger while BUSY: ignored; RETRIG_CNT increments, saturating at 255. RETRIG_CNT is cleared only by RESET.
- Input changes mid-train have no effect; the latched values are used for the whole train.
- Reset values: ACQ_EN, ACQ_START, ACQ_DONE, ACQ_ABORT, BUSY = 0; ECHO_IDX, RETRIG_CNT = 0; state IDLE.
- Synchronizer and edge register are cleared to 0, so an ACQ_WND already high at reset release is a trigger.

## Timing
- All outputs are registered.
- Let T0 be the clock edge at which IDLE accepts the trigger. T0 lies SYNC_STAGES+1 edges after ACQ_WND is first sampled high.
- D = max(ADC_INIT_DELAY,1); S = SAMPLES_PER_ECHO; G = ECHO_GAP.
- BUSY rises at T0.
- Echo k (0-based):
  - ACQ_EN rises at T0+D+k(S+G) and falls at T0+D+k(S+G)+S;
  - ACQ_START is high for exactly the first cycle of that window;
  - ECHO_IDX = k throughout the window.
- G==0: ACQ_EN stays continuously high across echoes, and ACQ_START still pulses each S cycles.
- Last ACQ_EN fall edge:
  - ACQ_DONE high for one cycle; BUSY low; ECHO_IDX returns to 0.
  - A trigger is accepted on the very next edge.
- Total train length: D + N·S + (N-1)·G cycles from T0.

## Configuration
- ACQ_WINGEN_ABORT_EN defined:
  - sync ACQ_WND low while in DELAY, ACQ or GAP aborts the train on the next edge;
  - ACQ_EN=0, BUSY=0, ECHO_IDX=0, state IDLE;
  - ACQ_ABORT pulses once and ACQ_DONE does not pulse.
- ACQ_WINGEN_ABORT_EN not defined: the falling edge of ACQ_WND is ignored, the train always completes, and ACQ_ABORT is tied 0.

## Test plan
- Basic train: DELAY=5, S=4, N=3, G=2, one ACQ_WND pulse -> ACQ_EN high at T0+5..8, T0+11..14, T0+17..20; three ACQ_START pulses; ECHO_IDX 0/1/2; ACQ_DONE at T0+21.
- Back-to-back echoes: DELAY=0, S=3, N=2, G=0 -> ACQ_EN high T0+1..6 with no gap; ACQ_START at T0+1 and T0+4.
- Zero counts: S=0 or N=0 -> ACQ_EN never asserted; ACQ_DONE pulses once; BUSY stays 0.
- Retriggers: three extra ACQ_WND pulses during a train -> train timing unchanged; RETRIG_CNT=3. A 300-retrigger run -> RETRIG_CNT=255.
- Abort, with ACQ_WINGEN_ABORT_EN defined: ACQ_WND drops mid-echo 1 -> ACQ_EN low within SYNC_STAGES+2 cycles; one ACQ_ABORT pulse; no ACQ_DONE. Without the macro -> full train completes.
- Reset: RESET asserted mid-ACQ -> all outputs 0 immediately; the next ACQ_WND rise starts a fresh train with ECHO_IDX=0.
